seven_segment_counter_mux: RTL and testbench
============================================

SEVEN_SEGMENT_COUNTER_MUX -- requirements
Module: seven_segment_counter_mux

Interface
REQ-001 SHALL have parameter TICK_DIV, default 16_000_000, clocks per count tick (legal minimum 2).
REQ-002 SHALL have parameter NUM_DIGITS, default 4, BCD digits counted and displayed (legal 1..8).
REQ-003 SHALL have parameter SCAN_DIV, default 16_000, clocks each digit is displayed per scan step (legal minimum 1).
REQ-004 SHALL have parameter ACTIVE_LOW, default 0; 1 inverts seg and digit_en (common-anode drive).
REQ-005 SHALL have parameter LZ_BLANK, default 1; 1 enables leading-zero blanking.
REQ-006 SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port run, input, 1 bit: 1 = prescaler advances; 0 = prescaler and count hold.
REQ-009 SHALL have port down, input, 1 bit: 0 = count up, 1 = count down, sampled on tick cycle.
REQ-010 SHALL have port clear, input, 1 bit: synchronous zero of count and prescaler.
REQ-011 SHALL have port seg, output, 7 bits: segments {a,b,c,d,e,f,g} = seg[6:0], a top, clockwise, g middle.
REQ-012 SHALL have port digit_en, output, NUM_DIGITS bits: one-hot digit select, bit 0 = least significant digit.
REQ-013 SHALL have port bcd, output, 4*NUM_DIGITS bits: current count, digit i at bcd[4i+3:4i].
REQ-014 SHALL have port tick, output, 1 bit: one-cycle pulse in the first cycle a new count is visible on bcd.
REQ-015 SHALL have port wrap, output, 1 bit: one-cycle pulse coincident with tick when count wrapped.

Function
REQ-016 SHALL keep prescaler 0..TICK_DIV-1; when run=1 and prescaler=TICK_DIV-1, next edge sets prescaler 0, updates count, asserts tick for one cycle.
REQ-017 SHALL, on tick with down=0, increment count as cascaded BCD: digit 9 -> 0 with carry; all-9s -> all-0s with wrap=1.
REQ-018 SHALL, on tick with down=1, decrement as cascaded BCD: digit 0 -> 9 with borrow; all-0s -> all-9s with wrap=1.
REQ-019 SHALL never hold a digit value above 9.
REQ-020 SHALL give priority reset > clear > tick; clear zeroes count and prescaler, suppresses that cycle's tick/wrap, leaves scan state running.
REQ-021 SHALL keep scan counter 0..SCAN_DIV-1 and digit index 0..NUM_DIGITS-1, advancing index (wrap to 0) when scan counter = SCAN_DIV-1; scan runs regardless of run.
REQ-022 SHALL drive digit_en one-hot at current index and seg with the decode of the indexed digit, both decoded from registered state only (no input-to-output combinational path).
REQ-023 SHALL decode active-high: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, blank=0000000.
REQ-024 SHALL, with LZ_BLANK=1, blank digit i>0 when it and all higher digits are 0; digit 0 never blanked; digit_en still asserted for blanked digit.
REQ-025 SHALL apply ACTIVE_LOW inversion to seg and digit_en after decode/blanking.
REQ-026 SHALL, with run=0, freeze prescaler value and resume from it when run returns to 1.

Reset
REQ-027 SHALL on reset set count, prescaler, scan counter, index to 0, tick=0, wrap=0.
REQ-028 SHALL present after reset (ACTIVE_LOW=0): bcd=0, digit_en=...0001, seg=1111110; reset mid-tick-cycle wins over tick.

Verification
REQ-029 TICK_DIV=4, NUM_DIGITS=2, run=1, down=0 from reset -> tick every 4th cycle, bcd 00,01..09,10; at 99 next tick bcd=00 with wrap=1.
REQ-030 down=1 from reset -> first tick bcd=99, wrap=1; next tick 98; 90 -> 89 on borrow.
REQ-031 run=0 with prescaler=2 for 10 cycles, then run=1 -> bcd unchanged during hold; tick 2 cycles after resume.
REQ-032 clear and tick-cycle together at bcd=37 -> bcd=00, tick=0, wrap=0; scan index unaffected.
REQ-033 SCAN_DIV=3, NUM_DIGITS=4, count 0007, LZ_BLANK=1 -> digit_en 0001,0010,0100,1000 each 3 cycles; seg 1110000 then 0000000 x3.
REQ-034 ACTIVE_LOW=1 after reset -> digit_en=...1110, seg=0000001; reset asserted mid-count -> all state zero next cycle.

Source files
------------

// File: rtl/seven_segment_counter_mux.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_counter_mux
// Description : Prescaled cascaded-BCD up/down counter with a multiplexed
//               seven-segment scan driver and leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_counter_mux #(
  parameter int TICK_DIV   = 16_000_000,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 16_000,
  parameter int ACTIVE_LOW = 0,
  parameter int LZ_BLANK   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    down,
  input  logic                    clear,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    tick,
  output logic                    wrap
);

  localparam int c_ps_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_sc_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_ix_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [c_ps_w-1:0] c_ps_max = c_ps_w'(TICK_DIV - 1);
  localparam logic [c_sc_w-1:0] c_sc_max = c_sc_w'(SCAN_DIV - 1);
  localparam logic [c_ix_w-1:0] c_ix_max = c_ix_w'(NUM_DIGITS - 1);

  logic [c_ps_w-1:0]       ps_q, ps_d;
  logic [4*NUM_DIGITS-1:0] count_q, count_d;
  logic                    tick_q, tick_d;
  logic                    wrap_q, wrap_d;
  logic [c_sc_w-1:0]       scan_q, scan_d;
  logic [c_ix_w-1:0]       idx_q, idx_d;

  logic [4*NUM_DIGITS-1:0] step_val;
  logic                    carry;
  logic [3:0]              digit;

  logic [NUM_DIGITS-1:0]   blank_vec;
  logic                    zero_above;
  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   en_raw;
  logic [6:0]              seg_raw;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Ripple the carry/borrow through the digits; a carry out of the top
  // digit is the wrap condition.
  always_comb begin
    step_val = count_q;
    carry    = 1'b1;
    digit    = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit = count_q[4*i +: 4];
      if (carry) begin
        if (!down) begin
          if (digit >= 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = digit + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (digit == 4'd0 || digit > 4'd9) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = digit - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    ps_d    = ps_q;
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (clear) begin
      ps_d    = '0;
      count_d = '0;
    end else if (run) begin
      if (ps_q == c_ps_max) begin
        ps_d    = '0;
        count_d = step_val;
        tick_d  = 1'b1;
        wrap_d  = carry;
      end else begin
        ps_d = ps_q + c_ps_w'(1);
      end
    end
  end

  always_comb begin
    scan_d = scan_q + c_sc_w'(1);
    idx_d  = idx_q;
    if (scan_q == c_sc_max) begin
      scan_d = '0;
      idx_d  = (idx_q == c_ix_max) ? '0 : idx_q + c_ix_w'(1);
    end
  end

  // Blank from the top down while every digit so far is zero; digit 0 always shows.
  always_comb begin
    zero_above = 1'b1;
    blank_vec  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (count_q[4*i +: 4] == 4'd0);
      if (LZ_BLANK != 0 && i > 0 && zero_above) begin
        blank_vec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    en_raw    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == c_ix_w'(i)) begin
        cur_digit = count_q[4*i +: 4];
        cur_blank = blank_vec[i];
        en_raw[i] = 1'b1;
      end
    end
    seg_raw = cur_blank ? 7'b0000000 : seg_decode(cur_digit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q    <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
    end else begin
      ps_q    <= ps_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
    end
  end

  assign seg      = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
  assign digit_en = (ACTIVE_LOW != 0) ? ~en_raw  : en_raw;
  assign bcd      = count_q;
  assign tick     = tick_q;
  assign wrap     = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_counter_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_counter_mux
// Description : Directed self-checking bench for seven_segment_counter_mux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_counter_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a: 2 digits, active-high; dut_b: 4 digits, active-low
  logic        reset_a, run_a, down_a, clear_a;
  logic [6:0]  seg_a;
  logic [1:0]  en_a;
  logic [7:0]  bcd_a;
  logic        tick_a, wrap_a;

  logic        reset_b, run_b, down_b, clear_b;
  logic [6:0]  seg_b;
  logic [3:0]  en_b;
  logic [15:0] bcd_b;
  logic        tick_b, wrap_b;

  seven_segment_counter_mux #(
    .TICK_DIV(4), .NUM_DIGITS(2), .SCAN_DIV(3), .ACTIVE_LOW(0), .LZ_BLANK(1)
  ) dut_a (
    .clk(clk), .reset(reset_a), .run(run_a), .down(down_a), .clear(clear_a),
    .seg(seg_a), .digit_en(en_a), .bcd(bcd_a), .tick(tick_a), .wrap(wrap_a)
  );

  seven_segment_counter_mux #(
    .TICK_DIV(4), .NUM_DIGITS(4), .SCAN_DIV(3), .ACTIVE_LOW(1), .LZ_BLANK(1)
  ) dut_b (
    .clk(clk), .reset(reset_b), .run(run_b), .down(down_b), .clear(clear_b),
    .seg(seg_b), .digit_en(en_b), .bcd(bcd_b), .tick(tick_b), .wrap(wrap_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc_a = 0;
  int cyc_b = 0;
  int idx;
  logic [1:0] e2;
  logic [3:0] e4;
  logic [6:0] e7;

  // Cycles since reset release; the scan index is (cycles / SCAN_DIV) mod digits.
  always @(posedge clk) cyc_a <= reset_a ? 0 : cyc_a + 1;
  always @(posedge clk) cyc_b <= reset_b ? 0 : cyc_b + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bcd2(input int n);
    return 8'(((n / 10) % 10) * 16 + (n % 10));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_a = 1'b1; run_a = 1'b0; down_a = 1'b0; clear_a = 1'b0;
    reset_b = 1'b1; run_b = 1'b0; down_b = 1'b0; clear_b = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_bcd_a",  bcd_a,  8'h00);
    chk("rst_en_a",   en_a,   2'b01);
    chk("rst_seg_a",  seg_a,  7'b1111110);
    chk("rst_tick_a", tick_a, 1'b0);
    chk("rst_wrap_a", wrap_a, 1'b0);
    chk("rst_bcd_b",  bcd_b,  16'h0000);
    chk("rst_en_b",   en_b,   4'b1110);
    chk("rst_seg_b",  seg_b,  7'b0000001);

    // Count up through 99 -> 00 and on to 01
    run_a = 1'b1; reset_a = 1'b0;
    for (int k = 1; k <= 101; k++) begin
      repeat (3) @(negedge clk);
      if (k <= 3) chk("up_quiet", tick_a, 1'b0);
      @(negedge clk);
      chk("up_tick", tick_a, 1'b1);
      chk("up_bcd",  bcd_a,  bcd2(k % 100));
      chk("up_wrap", wrap_a, (k == 100));
    end

    // Hold with prescaler at 2, then resume
    repeat (2) @(negedge clk);
    run_a = 1'b0;
    repeat (10) @(negedge clk);
    chk("hold_bcd",  bcd_a,  bcd2(1));
    chk("hold_tick", tick_a, 1'b0);
    run_a = 1'b1;
    @(negedge clk);
    chk("resume_quiet", tick_a, 1'b0);
    @(negedge clk);
    chk("resume_tick", tick_a, 1'b1);
    chk("resume_bcd",  bcd_a,  bcd2(2));

    // Advance to 37, then clear on the tick cycle
    repeat (35 * 4) @(negedge clk);
    chk("at37_bcd",  bcd_a,  bcd2(37));
    chk("at37_tick", tick_a, 1'b1);
    repeat (3) @(negedge clk);
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
    idx = (cyc_a / 3) % 2;
    e2 = 2'(1 << idx);
    e7 = (idx == 0) ? 7'b1111110 : 7'b0000000;
    chk("clr_bcd",  bcd_a,  8'h00);
    chk("clr_tick", tick_a, 1'b0);
    chk("clr_wrap", wrap_a, 1'b0);
    chk("clr_en",   en_a,   e2);
    chk("clr_seg",  seg_a,  e7);
    repeat (4) @(negedge clk);
    chk("post_clr_bcd",  bcd_a,  bcd2(1));
    chk("post_clr_tick", tick_a, 1'b1);

    // Count down from reset: 00 -> 99 with wrap, then 98 .. 89
    reset_a = 1'b1; down_a = 1'b1;
    repeat (2) @(negedge clk);
    reset_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("dn_bcd99",  bcd_a,  bcd2(99));
    chk("dn_wrap99", wrap_a, 1'b1);
    chk("dn_tick99", tick_a, 1'b1);
    for (int n = 98; n >= 89; n--) begin
      repeat (4) @(negedge clk);
      chk("dn_bcd",  bcd_a,  bcd2(n));
      chk("dn_wrap", wrap_a, 1'b0);
    end

    // Reset on the tick cycle wins
    repeat (3) @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    chk("rst_tick_bcd",  bcd_a,  8'h00);
    chk("rst_tick_tick", tick_a, 1'b0);
    chk("rst_tick_en",   en_a,   2'b01);
    reset_a = 1'b0;

    // Four-digit, active-low: count to 0007 and watch the scan
    run_b = 1'b1; reset_b = 1'b0;
    repeat (28) @(negedge clk);
    chk("b_bcd7",  bcd_b,  16'h0007);
    chk("b_tick7", tick_b, 1'b1);
    run_b = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      idx = (cyc_b / 3) % 4;
      e4 = ~4'(1 << idx);
      e7 = (idx == 0) ? 7'b0001111 : 7'b1111111;
      chk("b_scan_en",  en_b,  e4);
      chk("b_scan_seg", seg_b, e7);
    end

    // Reset mid-count
    run_b = 1'b1;
    repeat (9) @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    chk("b_rst_bcd",  bcd_b,  16'h0000);
    chk("b_rst_tick", tick_b, 1'b0);
    chk("b_rst_en",   en_b,   4'b1110);
    chk("b_rst_seg",  seg_b,  7'b0000001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
